seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Signed 32-bit iterative divider; the inverse companion to the datapath's sequential multiplier.
- Produces quotient (LO) and remainder (HI) for the DIV instruction.
- Uses a radix-2 restoring algorithm on operand magnitudes, then a sign-correction step.
- Sits beside the multiplier in the ALU; the control unit launches it with a start/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- dividend  in  WIDTH  signed numerator; captured on accepted start
- divisor  in  WIDTH  signed denominator; captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse; result valid
- quotient  out  WIDTH  signed quotient; held until the next done
- remainder  out  WIDTH  signed remainder; held until the next done
- div_by_zero  out  1  divisor was zero; updated with done

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States and transitions:
  - IDLE: start=1 at an edge latches |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend). Clears the partial remainder and count. Goes to CALC.
  - CALC: one quotient bit per edge, MSB first. Shift {rem, dvd} left by 1; trial = rem - |divisor| at WIDTH+1 bits. If trial ≥ 0: rem = trial, q bit = 1; else q bit = 0. Count 0..WIDTH-1; after bit WIDTH-1 goes to SIGN.
  - SIGN: quotient = sign_q ? -q : q; remainder = sign_r ? -rem : rem. Sets done=1 and busy=0. Goes to IDLE.
- Latency: start accepted at edge T0. CALC occupies T1..T32; SIGN executes at T33. done=1 in the cycle after T33, for exactly one cycle.
- Truncating division: the remainder carries the dividend's sign, and |remainder| < |divisor|.
- Magnitudes are computed at WIDTH+1 bits so -2^31 is exact.
- Overflow, -2^31 / -1: quotient = 0x80000000 (wraps), remainder = 0, no flag.
- start while busy: ignored; operands are not re-captured.
- start=1 in the same cycle done=1: accepted (the FSM is in IDLE), giving back-to-back operation.
- Operands may change after capture without effect.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - A zero divisor at start goes directly to SIGN, skipping CALC.
  - done occurs one cycle after acceptance.
  - quotient = 0xFFFFFFFF, remainder = dividend, div_by_zero = 1.
- Undefined:
  - The full 32-cycle algorithm runs with divisor 0; div_by_zero is still set with done.
  - Result is deterministic: magnitude q = 0xFFFFFFFF, rem = |dividend|.
  - After sign fix: quotient = 0x00000001 if dividend < 0, else 0xFFFFFFFF; remainder = dividend.

Decomposition:
- Shared package: WIDTH default constant, the state enum type (IDLE, CALC, SIGN), and the overflow constant 0x80000000.
- One sub-module: div_restore_step, a combinational single iteration.
  - Inputs: rem, dividend-MSB, divisor magnitude.
  - Outputs: next rem, quotient bit.
  - Instantiated once and reused each CALC cycle.

Test Plan:
- 100 / 7 -> quotient=14, remainder=2; done exactly 34 cycles after start; busy high for 33 cycles.
- -100 / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. 100 / -7 -> quotient=0xFFFFFFF2, remainder=2.
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
- -9 / 0:
  - with DIV_ZERO_FAST_EN -> done 2 cycles after start; quotient=0xFFFFFFFF, remainder=0xFFFFFFF7, div_by_zero=1.
  - without -> done at 34 cycles; quotient=0x00000001, remainder=0xFFFFFFF7, div_by_zero=1.
- Start 1000/3. Pulse start with 5/5 at cycle 10 -> ignored; result q=333, r=1. Start asserted in the done cycle -> next operation accepted with no idle gap.
- Assert clr at cycle 15 of an operation -> all outputs 0 immediately; no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential signed divider.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // -2^31 / -1 wraps to this quotient with no flag raised
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_QUOTIENT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

endpackage

// File: rtl/seq_divider_div_restore_step.sv
// One combinational radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;

  assign w_shift = {i_rem, i_dvd_msb};
  assign w_trial = {1'b0, w_shift} - (WIDTH+2)'(i_dvs);
  assign o_q     = ~w_trial[WIDTH+1];
  // Kept remainder is always below 2^WIDTH, so truncation loses nothing
  assign o_rem   = WIDTH'(o_q ? w_trial : {1'b0, w_shift});

endmodule

// File: rtl/seq_divider.sv
// Signed iterative divider (quotient/remainder, truncating). Optional macro DIV_ZERO_FAST_EN
// short-circuits a zero divisor straight to the sign-correction step.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_q_bit;
  logic             w_dvs_zero;

  // WIDTH-bit negation of the most negative value yields its exact unsigned magnitude
  assign w_dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_dvs_zero = (divisor == '0);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_dvs     (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_q       (w_q_bit)
  );

  // r_dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd    <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[WIDTH-1];
            r_dz     <= w_dvs_zero;
            r_rem    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= CALC;
`ifdef DIV_ZERO_FAST_EN
            if (w_dvs_zero) begin
              r_dvd    <= '1;
              r_rem    <= w_dvd_mag;
              r_sign_q <= 1'b0;
              r_state  <= SIGN;
            end
`endif
          end
        end
        CALC: begin
          r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_rem <= w_rem_nxt;
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state <= SIGN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SIGN: begin
          quotient    <= r_sign_q ? -r_dvd : r_dvd;
          remainder   <= r_sign_r ? -r_rem : r_rem;
          div_by_zero <= r_dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed + random scoreboard bench for seq_divider; expected latency follows DIV_ZERO_FAST_EN.
module tb_seq_divider;
  import seq_divider_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          bsy;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   start_cyc;
  int   busy_cnt;

  seq_divider dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat, input int ebsy);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.lat = elat; e.bsy = ebsy;
    sb_q.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    start_cyc = cyc;
    busy_cnt  = 0;
    tick();
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    while (done !== 1'b1 && (cyc - start_cyc) < 100) tick();
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    if (done === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_quotient"}, quotient, e.q);
      chk({tag, "_remainder"}, remainder, e.r);
      chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
      chk({tag, "_latency"}, 32'(cyc - start_cyc), 32'(e.lat));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.bsy));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quotient"}, quotient, 32'd0);
    chk({tag, "_remainder"}, remainder, 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    int a, b, mq, mr;
    int   zlat, zbsy;
    logic [31:0] zq;
    bit   seen;

`ifdef DIV_ZERO_FAST_EN
    zlat = 2;  zbsy = 1;  zq = 32'hFFFF_FFFF;
`else
    zlat = 34; zbsy = 33; zq = 32'h0000_0001;
`endif

    clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2 clr = 1'b0;
    #1 chk_reset_outputs("reset");
    tick(); tick();
    clr = 1'b1;
    tick();

    launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33);
    wait_done("p100_d7");
    tick();
    chk("done_single_cycle", 32'(done), 32'd0);
    chk("quotient_held", quotient, 32'd14);

    launch(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 33);
    wait_done("m100_d7");
    tick();
    launch(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 34, 33);
    wait_done("p100_m7");
    tick();

    launch(32'h8000_0000, 32'hFFFF_FFFF, DIV_OVF_QUOTIENT, 32'd0, 1'b0, 34, 33);
    wait_done("overflow");
    tick();

    launch(-32'sd9, 32'd0, zq, 32'hFFFF_FFF7, 1'b1, zlat, zbsy);
    wait_done("m9_d0");
    tick();

    // Start pulse mid-operation must not re-capture operands
    launch(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34, 33);
    repeat (8) tick();
    start = 1'b1; dividend = 32'd5; divisor = 32'd5;
    tick();
    start = 1'b0;
    wait_done("p1000_d3");
    launch(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34, 33);
    wait_done("back_to_back");
    tick();

    // Abort mid-operation with clr
    launch(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34, 33);
    repeat (13) tick();
    clr = 1'b0;
    #1 chk_reset_outputs("abort");
    void'(sb_q.pop_back());
    tick();
    clr = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    launch(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34, 33);
    wait_done("after_abort");
    tick();

    for (int i = 0; i < 6; i++) begin
      a = int'($urandom);
      b = int'($urandom_range(1, 100000));
      if (i % 2 == 1) b = -b;
      if (i == 4) a = -a;
      mq = a / b;
      mr = a % b;
      launch(32'(a), 32'(b), 32'(mq), 32'(mr), 1'b0, 34, 33);
      wait_done("random");
      tick();
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
